// File: rtl/regfile_reader.sv
// Sweeps an inclusive register range two at a time through both read ports
// and streams (index, value) beats out over a valid/ready handshake.
module regfile_reader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       first_addr,
    input  logic [3:0]       last_addr,
    output logic [3:0]       ra1,
    output logic [3:0]       ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_EMIT_A = 3'd2;
    localparam logic [2:0] S_EMIT_B = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cur_q, cur_d;
    logic [3:0]       last_q, last_d;
    logic [3:0]       ra1_q, ra1_d;
    logic [3:0]       ra2_q, ra2_d;
    logic [WIDTH-1:0] buf_a_q, buf_a_d;
    logic [WIDTH-1:0] buf_b_q, buf_b_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        cur_d   = first_addr;
                        last_d  = last_addr;
                        ra1_d   = first_addr;
                        ra2_d   = first_addr + 4'd1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                buf_a_d = rd1;
                buf_b_d = rd2;
                state_d = S_EMIT_A;
            end
            S_EMIT_A: begin
                if (out_ready) begin
                    state_d = (cur_q == last_q) ? S_DONE : S_EMIT_B;
                end
            end
            S_EMIT_B: begin
                if (out_ready) begin
                    // ra2 may wrap past 15 here; that beat is never emitted
                    if (cur_q + 4'd1 == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + 4'd2;
                        ra1_d   = cur_q + 4'd2;
                        ra2_d   = cur_q + 4'd3;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

    assign ra1       = ra1_q;
    assign ra2       = ra2_q;
    assign out_valid = (state_q == S_EMIT_A) || (state_q == S_EMIT_B);
    assign out_addr  = (state_q == S_EMIT_B) ? cur_q + 4'd1 : cur_q;
    assign out_data  = (state_q == S_EMIT_B) ? buf_b_q : buf_a_q;
    assign busy      = (state_q == S_READ) || out_valid;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader; register file model holds Rn=n,
// except r15=1515.
module tb_regfile_reader;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       first_addr;
    logic [3:0]       last_addr;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_addr;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rf(input logic [3:0] a);
        return (a == 4'd15) ? WIDTH'(1515) : WIDTH'(a);
    endfunction

    assign rd1 = rf(ra1);
    assign rd2 = rf(ra2);

    regfile_reader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [3:0] a,
                        input logic [31:0] d);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " addr"}, 32'(out_addr), 32'(a));
        chk({tag, " data"}, out_data, d);
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic idle_chk(input string tag, input logic exp_done);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic go(input logic [3:0] f, input logic [3:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        first_addr = 4'd0;
        last_addr  = 4'd0;
        out_ready  = 1'b1;
        tick();
        tick();
        idle_chk("rst", 1'b0);
        chk("rst ra1", 32'(ra1), 32'd0);
        chk("rst ra2", 32'(ra2), 32'd0);
        chk("rst addr", 32'(out_addr), 32'd0);
        chk("rst data", out_data, 32'd0);
        reset = 1'b0;
        tick();
        idle_chk("idle", 1'b0);

        // 0..3, ready high
        go(4'd0, 4'd3);
        chk("s1 read valid", 32'(out_valid), 32'd0);
        chk("s1 read busy", 32'(busy), 32'd1);
        chk("s1 ra1", 32'(ra1), 32'd0);
        chk("s1 ra2", 32'(ra2), 32'd1);
        tick();
        beat("s1 b0", 4'd0, 32'd0);
        tick();
        beat("s1 b1", 4'd1, 32'd1);
        tick();
        chk("s1 read2 valid", 32'(out_valid), 32'd0);
        chk("s1 ra1 2", 32'(ra1), 32'd2);
        chk("s1 ra2 2", 32'(ra2), 32'd3);
        tick();
        beat("s1 b2", 4'd2, 32'd2);
        tick();
        beat("s1 b3", 4'd3, 32'd3);
        tick();
        idle_chk("s1 done", 1'b1);
        tick();
        idle_chk("s1 idle", 1'b0);

        // 2..2 single beat
        go(4'd2, 4'd2);
        chk("s2 ra2", 32'(ra2), 32'd3);
        tick();
        beat("s2 b0", 4'd2, 32'd2);
        tick();
        idle_chk("s2 done", 1'b1);
        tick();
        idle_chk("s2 idle", 1'b0);

        // 0..1 with backpressure on beat 0
        out_ready = 1'b0;
        go(4'd0, 4'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            beat("s3 hold", 4'd0, 32'd0);
            tick();
        end
        beat("s3 hold", 4'd0, 32'd0);
        out_ready = 1'b1;
        tick();
        beat("s3 b1", 4'd1, 32'd1);
        tick();
        idle_chk("s3 done", 1'b1);
        tick();

        // 14..15 with stray start mid-sweep
        go(4'd14, 4'd15);
        chk("s4 ra1", 32'(ra1), 32'd14);
        chk("s4 ra2", 32'(ra2), 32'd15);
        tick();
        beat("s4 b0", 4'd14, 32'd14);
        first_addr = 4'd0;
        last_addr  = 4'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        beat("s4 b1", 4'd15, 32'd1515);
        tick();
        idle_chk("s4 done", 1'b1);
        tick();
        idle_chk("s4 idle", 1'b0);
        tick();
        idle_chk("s4 no restart", 1'b0);

        // empty range
        go(4'd5, 4'd3);
        idle_chk("s5 done", 1'b1);
        tick();
        idle_chk("s5 idle", 1'b0);

        // reset mid-sweep, reset beats start, then a normal sweep
        go(4'd0, 4'd7);
        tick();
        beat("s6 b0", 4'd0, 32'd0);
        tick();
        beat("s6 b1", 4'd1, 32'd1);
        reset = 1'b1;
        tick();
        idle_chk("s6 abort", 1'b0);
        chk("s6 ra1", 32'(ra1), 32'd0);
        chk("s6 addr", 32'(out_addr), 32'd0);
        chk("s6 data", out_data, 32'd0);
        first_addr = 4'd4;
        last_addr  = 4'd5;
        start      = 1'b1;
        tick();
        idle_chk("s6 rst prio", 1'b0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        idle_chk("s6 quiet", 1'b0);
        go(4'd4, 4'd5);
        tick();
        beat("s6 r b0", 4'd4, 32'd4);
        tick();
        beat("s6 r b1", 4'd5, 32'd5);
        tick();
        idle_chk("s6 r done", 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
